// File: rtl/ccd_dvp_capture.sv
`default_nettype none
//==============================================================================
// Module   : ccd_dvp_capture
// Brief    : DVP camera capture front end. Samples the sensor byte bus in the
//            PCLK domain, packs byte pairs into RGB565 pixels and emits a
//            valid-qualified stream with SOF/EOL markers. Measures frame
//            geometry and flags malformed lines.
// Options  : DVP_CAPTURE_SIZE_CHECK_EN - when defined, compares each line's
//            pixel count with H_PIXELS and each frame's line count with
//            V_LINES and raises sticky size_err on a mismatch.
// Revision : 1.0 - initial release
//==============================================================================
module ccd_dvp_capture #(
    parameter int FRAME_SKIP = 2,
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 240
) (
    input  logic        CCD_PCLK,
    input  logic        CCD_RSTN,
    input  logic        CCD_VSYNC,
    input  logic        CCD_HSYNC,
    input  logic [7:0]  CCD_DATA,
    input  logic        capture_en,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [11:0] h_size,
    output logic [11:0] v_size,
    output logic        line_err,
    output logic        size_err
);

    typedef enum logic [1:0] {
        ST_WAIT_BLANK = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_SKIP       = 2'd2,
        ST_ACTIVE     = 2'd3
    } state_t;

    localparam logic [11:0] c_CNT_MAX = 12'hFFF;

    // Two-stage input sampling; s1 doubles as one-cycle lookahead for s2
    logic       r_s1_vs, r_s1_hs;
    logic [7:0] r_s1_data;
    logic       r_s2_vs, r_s2_hs;
    logic [7:0] r_s2_data;
    logic       r_vs_d;

    state_t      r_state;
    logic [15:0] r_skip_cnt;
    logic        r_phase;
    logic [7:0]  r_byte_hi;
    logic [11:0] r_pix_cnt;
    logic [11:0] r_line_cnt;
    logic        r_line_open;
    logic        r_sof_pending;

    logic        r_pix_valid;
    logic [15:0] r_pix_data;
    logic        r_pix_sof;
    logic        r_pix_eol;
    logic        r_frame_done;
    logic [15:0] r_frame_cnt;
    logic [11:0] r_h_size;
    logic [11:0] r_v_size;
    logic        r_line_err;

    logic        w_byte;
    logic        w_last;
    logic        w_frame_end;
    logic        w_frame_start;
    logic [11:0] w_pix_next;
    logic [11:0] w_line_next;
    logic [11:0] w_v_final;

    // Byte present in s2 during an active frame; last byte when s1 shows HSYNC low
    assign w_byte        = r_s2_hs && !r_s2_vs;
    assign w_last        = w_byte && !r_s1_hs;
    // VSYNC rising seen in s2 closes a frame
    assign w_frame_end   = r_s2_vs && !r_vs_d;
    // VSYNC falling seen one cycle early so the first byte of the frame is not lost
    assign w_frame_start = r_s2_vs && !r_s1_vs;
    assign w_pix_next    = (r_pix_cnt  == c_CNT_MAX) ? r_pix_cnt  : r_pix_cnt  + 12'd1;
    assign w_line_next   = (r_line_cnt == c_CNT_MAX) ? r_line_cnt : r_line_cnt + 12'd1;
    // A line still open when VSYNC rises counts toward the frame height
    assign w_v_final     = r_line_open ? w_line_next : r_line_cnt;

`ifdef DVP_CAPTURE_SIZE_CHECK_EN
    logic r_size_err;
    assign size_err = r_size_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{12'(H_PIXELS), 12'(V_LINES)};
    assign size_err     = 1'b0;
`endif

    // Input synchroniser registers plus delayed s2 VSYNC for edge detection
    always_ff @(posedge CCD_PCLK or negedge CCD_RSTN) begin
        if (!CCD_RSTN) begin
            r_s1_vs   <= 1'b0;
            r_s1_hs   <= 1'b0;
            r_s1_data <= 8'd0;
            r_s2_vs   <= 1'b0;
            r_s2_hs   <= 1'b0;
            r_s2_data <= 8'd0;
            r_vs_d    <= 1'b0;
        end else begin
            r_s1_vs   <= CCD_VSYNC;
            r_s1_hs   <= CCD_HSYNC;
            r_s1_data <= CCD_DATA;
            r_s2_vs   <= r_s1_vs;
            r_s2_hs   <= r_s1_hs;
            r_s2_data <= r_s1_data;
            r_vs_d    <= r_s2_vs;
        end
    end

    // Frame gating FSM, byte packer, geometry counters and registered outputs
    always_ff @(posedge CCD_PCLK or negedge CCD_RSTN) begin
        if (!CCD_RSTN) begin
            r_state       <= ST_WAIT_BLANK;
            r_skip_cnt    <= 16'd0;
            r_phase       <= 1'b0;
            r_byte_hi     <= 8'd0;
            r_pix_cnt     <= 12'd0;
            r_line_cnt    <= 12'd0;
            r_line_open   <= 1'b0;
            r_sof_pending <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= 16'd0;
            r_pix_sof     <= 1'b0;
            r_pix_eol     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_h_size      <= 12'd0;
            r_v_size      <= 12'd0;
            r_line_err    <= 1'b0;
`ifdef DVP_CAPTURE_SIZE_CHECK_EN
            r_size_err    <= 1'b0;
`endif
        end else begin
            r_pix_valid  <= 1'b0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                ST_WAIT_BLANK: begin
                    // Only start looking for frames once blanking is seen
                    if (r_s2_vs) begin
                        r_state <= ST_WAIT_FRAME;
                    end
                end

                ST_WAIT_FRAME: begin
                    if (w_frame_start) begin
                        if (32'(r_skip_cnt) < FRAME_SKIP) begin
                            r_skip_cnt <= r_skip_cnt + 16'd1;
                            r_state    <= ST_SKIP;
                        end else if (capture_en) begin
                            r_state       <= ST_ACTIVE;
                            r_phase       <= 1'b0;
                            r_pix_cnt     <= 12'd0;
                            r_line_cnt    <= 12'd0;
                            r_line_open   <= 1'b0;
                            r_sof_pending <= 1'b1;
                            r_line_err    <= 1'b0;
`ifdef DVP_CAPTURE_SIZE_CHECK_EN
                            r_size_err    <= 1'b0;
`endif
                        end else begin
                            r_state <= ST_SKIP;
                        end
                    end
                end

                ST_SKIP: begin
                    if (w_frame_end) begin
                        r_state <= ST_WAIT_FRAME;
                    end
                end

                ST_ACTIVE: begin
                    if (w_frame_end) begin
                        r_state      <= ST_WAIT_FRAME;
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 16'd1;
                        r_v_size     <= w_v_final;
                        r_phase      <= 1'b0;
                        r_line_open  <= 1'b0;
                        if (r_phase) begin
                            r_line_err <= 1'b1;
                        end
`ifdef DVP_CAPTURE_SIZE_CHECK_EN
                        if (w_v_final != 12'(V_LINES)) begin
                            r_size_err <= 1'b1;
                        end
`endif
                    end else if (w_byte) begin
                        r_line_open <= 1'b1;
                        if (!r_phase) begin
                            r_byte_hi <= r_s2_data;
                            r_phase   <= 1'b1;
                            if (w_last) begin
                                // Dangling byte at line end: drop it and flag the line
                                r_phase     <= 1'b0;
                                r_line_err  <= 1'b1;
                                r_line_cnt  <= w_line_next;
                                r_pix_cnt   <= 12'd0;
                                r_line_open <= 1'b0;
                                if (r_line_cnt == 12'd0) begin
                                    r_h_size <= r_pix_cnt;
                                end
`ifdef DVP_CAPTURE_SIZE_CHECK_EN
                                if (r_pix_cnt != 12'(H_PIXELS)) begin
                                    r_size_err <= 1'b1;
                                end
`endif
                            end
                        end else begin
                            r_phase       <= 1'b0;
                            r_pix_valid   <= 1'b1;
                            r_pix_data    <= {r_byte_hi, r_s2_data};
                            r_pix_sof     <= r_sof_pending;
                            r_sof_pending <= 1'b0;
                            r_pix_eol     <= w_last;
                            r_pix_cnt     <= w_pix_next;
                            if (w_last) begin
                                r_line_cnt  <= w_line_next;
                                r_pix_cnt   <= 12'd0;
                                r_line_open <= 1'b0;
                                if (r_line_cnt == 12'd0) begin
                                    r_h_size <= w_pix_next;
                                end
`ifdef DVP_CAPTURE_SIZE_CHECK_EN
                                if (w_pix_next != 12'(H_PIXELS)) begin
                                    r_size_err <= 1'b1;
                                end
`endif
                            end
                        end
                    end else if (!r_s2_hs) begin
                        r_phase <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_WAIT_BLANK;
                end
            endcase
        end
    end

    assign pix_valid  = r_pix_valid;
    assign pix_data   = r_pix_data;
    assign pix_sof    = r_pix_sof;
    assign pix_eol    = r_pix_eol;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign h_size     = r_h_size;
    assign v_size     = r_v_size;
    assign line_err   = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_ccd_dvp_capture.sv
`default_nettype none
//==============================================================================
// Module   : tb_ccd_dvp_capture
// Brief    : Directed self-checking bench for ccd_dvp_capture. Honours
//            DVP_CAPTURE_SIZE_CHECK_EN for the size_err expectation.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ccd_dvp_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b1;
    logic        hs = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        en = 1'b1;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [11:0] h_size;
    logic [11:0] v_size;
    logic        line_err;
    logic        size_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] byte_ctr = 8'd1;

    int          mon_pix = 0, mon_sof = 0, mon_eol = 0, mon_done = 0;
    int          mon_eol_bad = 0, mon_idx = 0;
    logic [15:0] mon_last = 16'd0, mon_sof_data = 16'd0;

    ccd_dvp_capture #(
        .FRAME_SKIP (2),
        .H_PIXELS   (32),
        .V_LINES    (24)
    ) dut (
        .CCD_PCLK   (clk),
        .CCD_RSTN   (rst_n),
        .CCD_VSYNC  (vs),
        .CCD_HSYNC  (hs),
        .CCD_DATA   (data),
        .capture_en (en),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .h_size     (h_size),
        .v_size     (v_size),
        .line_err   (line_err),
        .size_err   (size_err)
    );

    always #5 clk = ~clk;

    // Stream monitor: tallies pulses and tracks pixel position within the frame
    always @(posedge clk) begin
        #1;
        if (pix_valid) begin
            mon_pix++;
            if (pix_sof) begin
                mon_sof++;
                mon_sof_data = pix_data;
                mon_idx = 0;
            end else begin
                mon_idx++;
            end
            mon_last = pix_data;
            if (pix_eol) begin
                mon_eol++;
                if ((mon_idx % 32) != 31) mon_eol_bad++;
            end
        end
        if (frame_done) mon_done++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hs = 1'b1;
            data = byte_ctr;
            byte_ctr = byte_ctr + 8'd1;
        end
    endtask

    task automatic send_line(input int n);
        send_bytes(n);
        @(negedge clk);
        hs = 1'b0;
        data = 8'd0;
        idle(4);
    endtask

    task automatic start_frame();
        @(negedge clk);
        vs = 1'b0;
        byte_ctr = 8'd1;
        idle(4);
    endtask

    task automatic end_frame();
        @(negedge clk);
        vs = 1'b1;
        idle(12);
    endtask

    task automatic send_frame(input int lines, input int odd_line);
        start_frame();
        for (int l = 0; l < lines; l++) send_line((l == odd_line) ? 63 : 64);
        end_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_tests++;
        if ({pix_valid, pix_sof, pix_eol, frame_done, line_err, size_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000000",
                     {pix_valid, pix_sof, pix_eol, frame_done, line_err, size_err});
        end
        n_tests++;
        if ({pix_data, frame_cnt, h_size, v_size} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_values data=%h fcnt=%0d h=%0d v=%0d want all 0",
                     pix_data, frame_cnt, h_size, v_size);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_skip();
        int p0, s0, e0, b0, d0;
        p0 = mon_pix; d0 = mon_done;
        send_frame(24, -1);
        send_frame(24, -1);
        n_tests++;
        if (mon_pix - p0 != 0 || mon_done - d0 != 0) begin
            n_fail++;
            $display("FAIL skip_frames pixels=%0d done=%0d want 0 0", mon_pix - p0, mon_done - d0);
        end
        p0 = mon_pix; s0 = mon_sof; e0 = mon_eol; b0 = mon_eol_bad; d0 = mon_done;
        send_frame(24, -1);
        n_tests++;
        if (mon_pix - p0 != 768) begin
            n_fail++;
            $display("FAIL capture_pixels got=%0d want=768", mon_pix - p0);
        end
        n_tests++;
        if (mon_sof - s0 != 1 || mon_sof_data !== 16'h0102) begin
            n_fail++;
            $display("FAIL sof got_cnt=%0d data=%h want 1 0102", mon_sof - s0, mon_sof_data);
        end
        n_tests++;
        if (mon_eol - e0 != 24 || mon_eol_bad - b0 != 0) begin
            n_fail++;
            $display("FAIL eol got_cnt=%0d misplaced=%0d want 24 0", mon_eol - e0, mon_eol_bad - b0);
        end
        n_tests++;
        if (mon_last !== 16'hFF00) begin
            n_fail++;
            $display("FAIL last_pixel got=%h want=ff00", mon_last);
        end
        n_tests++;
        if (mon_done - d0 != 1 || h_size !== 12'd32 || v_size !== 12'd24 || frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL geometry done=%0d h=%0d v=%0d fcnt=%0d want 1 32 24 1",
                     mon_done - d0, h_size, v_size, frame_cnt);
        end
        n_tests++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_line_err got=%b want=0", line_err);
        end
    endtask

    task automatic test_latency();
        start_frame();
        @(negedge clk); hs = 1'b1; data = 8'h01;
        @(negedge clk); data = 8'h02;
        @(posedge clk);              // edge N samples second byte
        @(negedge clk); data = 8'h03;
        @(posedge clk); #1;          // N+1
        n_tests++;
        if (pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_n1 got=%b want=0", pix_valid);
        end
        @(negedge clk); data = 8'h04;
        @(posedge clk); #1;          // N+2
        n_tests++;
        if (pix_valid !== 1'b1 || pix_data !== 16'h0102 || pix_sof !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_n2 valid=%b data=%h sof=%b want 1 0102 1", pix_valid, pix_data, pix_sof);
        end
        byte_ctr = 8'd5;
        send_bytes(60);
        @(negedge clk); hs = 1'b0; data = 8'd0;
        idle(4);
        for (int l = 1; l < 24; l++) send_line(64);
        end_frame();
        n_tests++;
        if (frame_cnt !== 16'd2 || v_size !== 12'd24) begin
            n_fail++;
            $display("FAIL latency_frame fcnt=%0d v=%0d want 2 24", frame_cnt, v_size);
        end
    endtask

    task automatic test_gating();
        int p0, d0;
        p0 = mon_pix; d0 = mon_done;
        en = 1'b0;
        start_frame();
        for (int l = 0; l < 3; l++) send_line(64);
        en = 1'b1;
        for (int l = 3; l < 24; l++) send_line(64);
        end_frame();
        n_tests++;
        if (mon_pix - p0 != 0 || mon_done - d0 != 0 || frame_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL gated_frame pixels=%0d done=%0d fcnt=%0d want 0 0 2",
                     mon_pix - p0, mon_done - d0, frame_cnt);
        end
        p0 = mon_pix;
        send_frame(24, -1);
        n_tests++;
        if (mon_pix - p0 != 768 || frame_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL after_gate pixels=%0d fcnt=%0d want 768 3", mon_pix - p0, frame_cnt);
        end
    endtask

    task automatic test_odd_line();
        int p0, e0;
        p0 = mon_pix; e0 = mon_eol;
        send_frame(24, 5);
        n_tests++;
        if (mon_pix - p0 != 767 || mon_eol - e0 != 23) begin
            n_fail++;
            $display("FAIL odd_line pixels=%0d eol=%0d want 767 23", mon_pix - p0, mon_eol - e0);
        end
        n_tests++;
        if (line_err !== 1'b1 || h_size !== 12'd32 || v_size !== 12'd24) begin
            n_fail++;
            $display("FAIL odd_flags line_err=%b h=%0d v=%0d want 1 32 24", line_err, h_size, v_size);
        end
        start_frame();
        n_tests++;
        if (line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL line_err_clear got=%b want=0", line_err);
        end
        for (int l = 0; l < 24; l++) send_line(64);
        end_frame();
    endtask

    task automatic test_size();
        logic exp_err;
`ifdef DVP_CAPTURE_SIZE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        send_frame(23, -1);
        n_tests++;
        if (size_err !== exp_err || v_size !== 12'd23 || frame_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL short_frame size_err=%b v=%0d fcnt=%0d want %b 23 6",
                     size_err, v_size, frame_cnt, exp_err);
        end
        send_frame(24, -1);
        n_tests++;
        if (size_err !== 1'b0 || v_size !== 12'd24) begin
            n_fail++;
            $display("FAIL good_frame size_err=%b v=%0d want 0 24", size_err, v_size);
        end
    endtask

    task automatic test_reset_mid();
        int p0, d0;
        start_frame();
        for (int l = 0; l < 10; l++) send_line(64);
        send_bytes(20);
        @(negedge clk); rst_n = 1'b0;
        idle(2);
        n_tests++;
        if ({pix_valid, frame_done, line_err} !== 3'b0 || frame_cnt !== 16'd0 ||
            h_size !== 12'd0 || v_size !== 12'd0 || pix_data !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset valid=%b done=%b lerr=%b fcnt=%0d h=%0d v=%0d data=%h want all 0",
                     pix_valid, frame_done, line_err, frame_cnt, h_size, v_size, pix_data);
        end
        @(negedge clk); rst_n = 1'b1;
        p0 = mon_pix; d0 = mon_done;
        send_bytes(44);
        @(negedge clk); hs = 1'b0; data = 8'd0;
        idle(4);
        for (int l = 11; l < 24; l++) send_line(64);
        end_frame();
        n_tests++;
        if (mon_pix - p0 != 0 || mon_done - d0 != 0) begin
            n_fail++;
            $display("FAIL partial_after_reset pixels=%0d done=%0d want 0 0", mon_pix - p0, mon_done - d0);
        end
        send_frame(24, -1);
        send_frame(24, -1);
        n_tests++;
        if (mon_pix - p0 != 0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reskip pixels=%0d fcnt=%0d want 0 0", mon_pix - p0, frame_cnt);
        end
        send_frame(24, -1);
        n_tests++;
        if (mon_pix - p0 != 768 || frame_cnt !== 16'd1 || h_size !== 12'd32) begin
            n_fail++;
            $display("FAIL recapture pixels=%0d fcnt=%0d h=%0d want 768 1 32",
                     mon_pix - p0, frame_cnt, h_size);
        end
    endtask

    initial begin
        test_reset();
        test_skip();
        test_latency();
        test_gating();
        test_odd_line();
        test_size();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccd_dvp_capture.md
# ccd_dvp_capture

DVP camera capture front end: samples the sensor's byte-wide parallel bus (PCLK, VSYNC, HREF-style HSYNC, 8-bit data) in the sensor clock domain. Packs byte pairs into 16-bit RGB565 pixels and emits them as a valid-qualified stream with start-of-frame and end-of-line markers. Measures frame geometry and flags malformed lines. Sits between the CCD pins and the streaming write path/async FIFO.

## Interface
- FRAME_SKIP, 2: frames discarded after reset (sensor settle).
- H_PIXELS, 320: expected pixels per line (used only with the size check).
- V_LINES, 240: expected lines per frame (used only with the size check).

Ports:
- CCD_PCLK  in  1  sensor pixel clock; sole clock, all logic on rising edge.
- CCD_RSTN  in  1  asynchronous active-low reset.
- CCD_VSYNC  in  1  high = vertical blanking, low = frame active.
- CCD_HSYNC  in  1  high = valid data byte on CCD_DATA.
- CCD_DATA  in  8  pixel byte.
- capture_en  in  1  frame-gating enable.
- pix_valid  out  1  pix_data valid this cycle.
- pix_data  out  16  {first byte, second byte}.
- pix_sof  out  1  with first pixel of a captured frame.
- pix_eol  out  1  with last pixel of each line.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_cnt  out  16  captured frames, wraps.
- h_size  out  12  pixels per line, first line of last captured frame.
- v_size  out  12  lines in last captured frame.
- line_err  out  1  sticky: odd byte count seen in a line.
- size_err  out  1  sticky geometry mismatch (macro only).

## Operation
- Input stage: VSYNC, HSYNC and DATA registered twice (s1, s2). All decisions use s2, with s1 as one-cycle lookahead.
- FSM:
  - WAIT_BLANK (reset state): wait for s2 VSYNC=1 → WAIT_FRAME. Guarantees no partial frame is captured after reset.
  - WAIT_FRAME: on s2 VSYNC 1→0, test the gate.
    - If skip_cnt<FRAME_SKIP: increment skip_cnt, → SKIP.
    - Else if capture_en=1: → ACTIVE.
    - Else: → SKIP.
  - SKIP: ignore data; on VSYNC 0→1 → WAIT_FRAME.
  - ACTIVE: pack bytes; on VSYNC 0→1 → WAIT_FRAME with frame_done=1, frame_cnt+1, latch v_size.
- capture_en is sampled only at the VSYNC falling edge. Changes mid-frame have no effect.
- Packing: byte phase toggles on each s2 HSYNC=1 byte and clears when HSYNC=0. The second byte completes a pixel.
- pix_sof: first completed pixel after entering ACTIVE.
- pix_eol: completed pixel whose s1 HSYNC=0.
- Line end: a line ends at HSYNC 1→0.
  - Line counter increments.
  - h_size is latched on line 0 of the frame.
  - If phase=1 (dangling byte): the byte is dropped, line_err=1, no pixel is emitted, and the previous pixel carries no eol.
- line_err and size_err clear on entry to ACTIVE.
- Counters: pixel counter 12-bit, line counter 12-bit, both saturating at 4095. frame_cnt wraps at 0xFFFF→0.
- Reset: all outputs 0, skip_cnt 0, FSM → WAIT_BLANK.

## Timing
- A byte sampled into s1 at edge N appears in s2 at edge N+1.
- Output registers load at N+2, so pixel outputs are visible after edge N+2, where N is the edge sampling the second byte. Fixed latency 2 cycles.
- pix_valid, pix_sof, pix_eol and frame_done are single-cycle pulses. At most one pixel every 2 cycles.
- frame_done is visible 2 cycles after the VSYNC rising edge is sampled into s1. v_size and frame_cnt update in the same cycle.
- pix_data holds its last value when pix_valid=0.
- VSYNC rising mid-line (HSYNC=1) ends the frame. The partial line counts toward v_size; line_err is set if the line has an odd byte count.

## Configuration
- DVP_CAPTURE_SIZE_CHECK_EN
  - Defined: at each line end, a pixel count ≠ H_PIXELS sets size_err. At frame end, a line count ≠ V_LINES sets size_err.
  - Undefined: check logic is absent and size_err is tied 0.

## Test plan
- Reset/skip: FRAME_SKIP=2, capture_en=1, frames of 24 lines × 64 bytes, bytes counting 1,2,3… from frame start.
  - First two frames: no pix_valid.
  - Third frame: first pixel 0x0102 with pix_sof.
  - Each line: 32 pixels; the 32nd carries pix_eol.
  - frame_done once; h_size=32, v_size=24, frame_cnt=1.
- Gating: capture_en=0 at VSYNC fall, raised mid-frame → no pixels that frame. Next frame is captured.
- Odd line: line 5 carries 63 bytes → 31 pixels, line_err=1, no eol on that line. line_err clears at the next frame start.
- Reset mid-frame: assert CCD_RSTN=0 during line 10, release with VSYNC low → outputs 0, no capture until a full blanking plus VSYNC fall is seen.
- Size check (macro defined, H_PIXELS=32, V_LINES=24): 23-line frame → size_err=1 at frame end. A correct frame clears it. Without the macro, size_err stays 0.
- Latency: the second byte of pixel 0 is sampled at edge N → pix_valid high exactly after edge N+2.
